uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `UARTReceiver`. Accepts bytes over the receiver's `valid`/`ready` handshake, stores them in a power-of-two circular FIFO, and presents them to the consumer (CPU bus bridge, command parser) over a show-ahead `valid`/`ready` interface. Latches receiver framing errors and overruns into sticky status flags so that bursts at 115200 baud are not lost while the consumer is busy.

## Interface

- `DEPTH`, 16: number of byte entries; power of two, 2..256.
- `ALMOST_FULL_LEVEL`, 12: `almost_full` asserts when `count >= ALMOST_FULL_LEVEL`; range 1..DEPTH.

- `clk`  in  1  single system clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; when low, all state is cleared immediately; release is synchronous to `clk` upstream.
- `clear`  in  1  synchronous flush; empties the FIFO and clears the sticky flags.
- `rx_data`  in  8  byte from receiver `out`.
- `rx_valid`  in  1  receiver `valid`; byte on `rx_data` is available.
- `rx_error`  in  1  receiver `error`; qualifies the byte currently offered.
- `rx_overrun`  in  1  receiver `overrun` pulse/level.
- `rx_ready`  out  1  to receiver `ready`; high when not full.
- `out_data`  out  8  byte at the FIFO head.
- `out_error`  out  1  error tag of the head byte (see Configuration).
- `out_valid`  out  1  head entry is valid (FIFO not empty).
- `out_ready`  in  1  consumer accepts the head byte.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `almost_full`  out  1  `count >= ALMOST_FULL_LEVEL`.
- `error_flag`  out  1  sticky: a byte arrived with `rx_error` high.
- `overrun_flag`  out  1  sticky: `rx_overrun` was seen high.

## Operation

- Storage: DEPTH-entry register array; write and read pointers are $clog2(DEPTH)+1 bits wide, and the MSB is the wrap bit. Empty when the pointers are equal; full when the low bits are equal and the MSBs differ. Pointers wrap naturally modulo 2·DEPTH.
- Write: `wr = rx_valid && rx_ready`. On `wr`, store `rx_data` (plus tag) at `wr_ptr` and increment `wr_ptr`.
- Read: `rd = out_valid && out_ready`. On `rd`, increment `rd_ptr`.
- Show-ahead: `out_data`/`out_error` are read combinationally from the entry at `rd_ptr`. Their values are undefined when `out_valid` is 0.
- `rx_ready = !full`, `out_valid = !empty`, `count = wr_ptr - rd_ptr`. There is no combinational path from `out_ready` to `rx_ready`.
- Simultaneous `wr` and `rd`: both happen and `count` is unchanged. When the FIFO is full, `rd` in a cycle does not enable a write in that same cycle; `rx_ready` rises on the next cycle.
- Sticky flags:
  - `error_flag` sets on a cycle where `wr && rx_error`.
  - `overrun_flag` sets on any cycle where `rx_overrun` is high.
  - Both hold until `clear` or `reset`.
- `clear` has priority over `wr`/`rd` in the same cycle. It zeros both pointers and both flags. Array contents are not cleared.
- Reset (including mid-transfer): pointers and flags go to 0 and any partially consumed data is discarded.

## Timing

- Reset values: `rx_ready`=1, `out_valid`=0, `count`=0, `almost_full`=0, `error_flag`=0, `overrun_flag`=0, `out_error`=0.
- Write-to-read latency: a byte written at edge N has `out_valid`=1 after edge N (visible during cycle N+1).
- `count`, `almost_full`, `rx_ready`, `out_valid` and the flags all update on the same edge as the pointer change. The flags are visible one cycle after the triggering input.
- Throughput: one write and one read per cycle.

## Configuration

- `UART_RX_FIFO_ERRTAG_EN` defined:
  - Entries are 9 bits: `{rx_error, rx_data}`.
  - Errored bytes are stored.
  - `out_error` presents the head byte's tag.
- Not defined:
  - Entries are 8 bits.
  - Bytes with `rx_valid && rx_error` are still handshaken (`rx_ready` as usual, `error_flag` sets) but are not written, so the pointers are unchanged.
  - `out_error` is tied to 0.

## Test plan

- Reset with `reset`=0 mid-stream, then release → `count`=0, `out_valid`=0, `rx_ready`=1, both flags 0.
- Write 0x41, 0x42, 0x43 with `out_ready`=0, then `out_ready`=1 → `out_data` 0x41, 0x42, 0x43 on consecutive cycles; `count` goes 3→0.
- With DEPTH=16, write 16 bytes with no reads → `rx_ready`=0 and `count`=16. `almost_full` goes high when `count` reaches 12. One read → `rx_ready`=1 next cycle. A 17th byte is then accepted and pointers wrap; the read order is preserved across the wrap.
- Full FIFO, `rx_valid`=1 and `out_ready`=1 in the same cycle → the read occurs, the write does not, and `count`=15. On the next cycle both occur and `count` stays 15.
- Byte 0x55 with `rx_error`=1:
  - With `UART_RX_FIFO_ERRTAG_EN`: stored, `out_error`=1 at the head, `error_flag`=1.
  - Without the macro: `count` stays 0 and `error_flag`=1.
- `rx_overrun` pulse for 1 cycle → `overrun_flag`=1 and it stays high. `clear`=1 together with `rx_valid`=1 → `count`=0, flags 0, and the byte is not stored.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: show-ahead output, 1-cycle write-to-read latency; rx_ready drops when full
// (a same-cycle read does not free a slot until the next edge). Define UART_RX_FIFO_ERRTAG_EN to store per-byte error tags.
module uart_rx_fifo #(
    parameter int DEPTH             = 16,
    parameter int ALMOST_FULL_LEVEL = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    input  logic                     rx_overrun,
    output logic                     rx_ready,
    output logic [7:0]               out_data,
    output logic                     out_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     error_flag,
    output logic                     overrun_flag
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);

`ifdef UART_RX_FIFO_ERRTAG_EN
    localparam int EW = 9;
`else
    localparam int EW = 8;
`endif

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          wr;
    logic          wr_en;
    logic          rd;

    // Full when the slot indices match but the wrap bits differ.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (wr_ptr == rd_ptr);

    assign rx_ready    = !full;
    assign out_valid   = !empty;
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (count >= AF_LEVEL);

    assign wr = rx_valid && rx_ready;
    assign rd = out_valid && out_ready;

`ifdef UART_RX_FIFO_ERRTAG_EN
    assign wr_en     = wr;
    assign entry     = {rx_error, rx_data};
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = head[7:0];
    assign out_error = out_valid && head[8];
`else
    // Errored bytes are handshaken so the receiver moves on, but dropped.
    assign wr_en     = wr && !rx_error;
    assign entry     = rx_data;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_data  = head;
    assign out_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            mem[wr_ptr[AW-1:0]] <= entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            error_flag   <= 1'b0;
            overrun_flag <= 1'b0;
        end else if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            error_flag   <= 1'b0;
            overrun_flag <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (wr && rx_error) begin
                error_flag <= 1'b1;
            end
            if (rx_overrun) begin
                overrun_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: stimulus queues expected head bytes, a negedge monitor checks them.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       clear;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic       rx_overrun;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_error;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       almost_full;
    logic       error_flag;
    logic       overrun_flag;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    uart_rx_fifo #(.DEPTH(16), .ALMOST_FULL_LEVEL(12)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_error(rx_error),
        .rx_overrun(rx_overrun), .rx_ready(rx_ready),
        .out_data(out_data), .out_error(out_error), .out_valid(out_valid),
        .out_ready(out_ready), .count(count), .almost_full(almost_full),
        .error_flag(error_flag), .overrun_flag(overrun_flag)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte for one cycle; exp_acc is the hand-derived rx_ready expectation.
    task automatic send(input logic [7:0] d, input logic err, input logic exp_acc);
        rx_data  = d;
        rx_error = err;
        rx_valid = 1'b1;
        chk("rx_ready_on_offer", int'(rx_ready), int'(exp_acc));
`ifdef UART_RX_FIFO_ERRTAG_EN
        if (exp_acc) sb.push_back({err, d});
`else
        if (exp_acc && !err) sb.push_back({1'b0, d});
`endif
        step();
        rx_valid = 1'b0;
        rx_error = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_rx_ready"}, int'(rx_ready), 1);
        chk({tag, "_almost_full"}, int'(almost_full), 0);
        chk({tag, "_error_flag"}, int'(error_flag), 0);
        chk({tag, "_overrun_flag"}, int'(overrun_flag), 0);
        chk({tag, "_out_error"}, int'(out_error), 0);
    endtask

    // Monitor: a read handshake will happen at the coming edge unless clear/reset intervenes.
    initial begin
        logic [8:0] exp;
        forever begin
            @(negedge clk);
            if (reset && !clear && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got data %0h with empty scoreboard", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data != exp[7:0] || out_error != exp[8]) begin
                        errors++;
                        $display("FAIL sb_head: got err=%0b data=%0h expected err=%0b data=%0h",
                                 out_error, out_data, exp[8], exp[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; clear = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        rx_error = 1'b0; rx_overrun = 1'b0; out_ready = 1'b0;
        #1 reset = 1'b0;
        #1 chk_idle("in_reset");
        step();
        reset = 1'b1;
        step();
        chk_idle("after_reset");

        // Three bytes held, then drained back-to-back.
        send(8'h41, 1'b0, 1'b1);
        send(8'h42, 1'b0, 1'b1);
        send(8'h43, 1'b0, 1'b1);
        chk("abc_count3", int'(count), 3);
        chk("abc_head_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        step(); chk("abc_count2", int'(count), 2);
        step(); chk("abc_count1", int'(count), 1);
        step(); chk("abc_count0", int'(count), 0);
        out_ready = 1'b0;
        chk("abc_empty", int'(out_valid), 0);

        // Fill to 16, watching almost_full cross at 12.
        for (int i = 0; i < 16; i++) begin
            send(8'h10 + 8'(i), 1'b0, 1'b1);
            chk("fill_count", int'(count), i + 1);
            chk("fill_almost_full", int'(almost_full), (i + 1 >= 12) ? 1 : 0);
        end
        chk("full_rx_ready", int'(rx_ready), 0);

        // Full: read happens, write does not; next cycle both happen across the wrap.
        out_ready = 1'b1;
        send(8'h99, 1'b0, 1'b0);
        chk("full_rd_only_count", int'(count), 15);
        chk("full_rx_ready_back", int'(rx_ready), 1);
        send(8'h99, 1'b0, 1'b1);
        chk("wrap_rd_wr_count", int'(count), 15);
        for (int i = 0; i < 15; i++) step();
        chk("drain_count", int'(count), 0);
        chk("drain_sb_empty", sb.size(), 0);
        out_ready = 1'b0;

        // Framing-error byte.
        send(8'h55, 1'b1, 1'b1);
        chk("err_flag", int'(error_flag), 1);
`ifdef UART_RX_FIFO_ERRTAG_EN
        chk("err_count", int'(count), 1);
        chk("err_out_error", int'(out_error), 1);
        chk("err_out_data", int'(out_data), 8'h55);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
`else
        chk("err_count", int'(count), 0);
        chk("err_out_valid", int'(out_valid), 0);
        chk("err_out_error", int'(out_error), 0);
`endif
        chk("err_drained", int'(count), 0);

        // Overrun pulse is sticky until clear; clear beats a concurrent write.
        rx_overrun = 1'b1;
        step();
        rx_overrun = 1'b0;
        chk("ovr_flag_set", int'(overrun_flag), 1);
        step(); step();
        chk("ovr_flag_held", int'(overrun_flag), 1);
        chk("err_flag_held", int'(error_flag), 1);
        clear = 1'b1;
        rx_data = 8'h77;
        rx_valid = 1'b1;
        step();
        clear = 1'b0;
        rx_valid = 1'b0;
        chk_idle("after_clear");

        // Reset mid-stream discards held bytes and flags.
        send(8'hA1, 1'b0, 1'b1);
        send(8'hA2, 1'b0, 1'b1);
        rx_data = 8'hA3; rx_valid = 1'b1; rx_overrun = 1'b1;
        step();
        chk("pre_reset_count", int'(count), 3);
        chk("pre_reset_ovr", int'(overrun_flag), 1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk_idle("mid_reset");
        rx_valid = 1'b0; rx_overrun = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk_idle("post_reset");

        // Post-reset sanity: FIFO still works.
        send(8'h5A, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("final_count", int'(count), 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
